// File: rtl/seg7_pkg.sv
// Shared glyph constants, digit-index type and glyph lookup for the
// four-digit multiplexed seven-segment scanner.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] SEL_NONE = 4'hF;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with blanking and decimal point.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] body;

  always_comb begin
    body = blank ? GLYPH_BLANK : glyph(nibble);
    seg  = {~dp, body};
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner: slot counter, digit index,
// frame-synchronous shadow register, leading-zero blanking, registered outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd24_999,
  parameter logic        LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] disp_num,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  logic [15:0] cnt_q;
  digit_idx_t  idx_q;
  logic [15:0] shadow_q;
  logic [7:0]  seg_q;
  logic [3:0]  sel_q;

  logic        slot_end;
  logic        frame_end;
  logic [3:0]  cur_nibble;
  logic        lead_zero;
  logic        cur_blank;
  logic        cur_dp;
  logic [7:0]  dec_seg;
  logic [3:0]  cur_sel;

  assign slot_end  = (cnt_q == SCAN_DIV);
  assign frame_end = slot_end && (idx_q == 2'd3);

  always_comb begin
    cur_nibble = 4'h0;
    lead_zero  = 1'b0;
    unique case (idx_q)
      2'd0: begin
        cur_nibble = shadow_q[3:0];
        lead_zero  = 1'b0;
      end
      2'd1: begin
        cur_nibble = shadow_q[7:4];
        lead_zero  = (shadow_q[15:4] == 12'h000);
      end
      2'd2: begin
        cur_nibble = shadow_q[11:8];
        lead_zero  = (shadow_q[15:8] == 8'h00);
      end
      default: begin
        cur_nibble = shadow_q[15:12];
        lead_zero  = (shadow_q[15:12] == 4'h0);
      end
    endcase
  end

  // dp follows the live mask so it can change mid-frame.
  always_comb begin
    cur_blank = LZB && lead_zero;
    cur_dp    = dp_mask[idx_q];
    cur_sel   = ~(4'b0001 << idx_q);
  end

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 16'h0000;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      seg_q    <= SEG_OFF;
      sel_q    <= SEL_NONE;
    end else begin
      cnt_q <= slot_end ? 16'h0000 : cnt_q + 16'd1;
      if (slot_end) begin
        idx_q <= idx_q + 2'd1;
      end
      if (frame_end) begin
        shadow_q <= disp_num;
      end
      if (en) begin
        seg_q <= dec_seg;
        sel_q <= cur_sel;
      end else begin
        seg_q <= SEG_OFF;
        sel_q <= SEL_NONE;
      end
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

endmodule
